sm3_msg_expnd: RTL and testbench

- SM3 message-expansion stage sitting directly upstream of the single-round compression datapath.
- Accepts one 512-bit padded message block. Streams W_j, W'_j, T_j<<<(j mod 32) and the round<16 flag for j = 0..63, one round per accepted handshake.
- Keeps a 16-word sliding window, so each round needs only one new word.

---
 rtl/sm3_msg_expnd.sv | 95 +++++++++
 tb/tb_sm3_msg_expnd.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sm3_msg_expnd.sv
// SM3 message expansion: one 512-bit block in, 64 rounds of W_j / W'_j / rotated T_j out.
// First round valid the cycle after acceptance; rounds advance only on w_valid_o && w_ready_i, outputs hold while stalled.
module sm3_msg_expnd #(
  parameter int NUM_ROUNDS = 64
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         flush_i,
  input  logic         blk_valid_i,
  output logic         blk_ready_o,
  input  logic [511:0] blk_data_i,
  output logic         w_valid_o,
  input  logic         w_ready_i,
  output logic [31:0]  wj_o,
  output logic [31:0]  wjj_o,
  output logic [31:0]  tj_o,
  output logic         round_sm_16_o,
  output logic [5:0]   round_o,
  output logic         done_o
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  localparam logic [31:0] T_LO = 32'h79CC4519;
  localparam logic [31:0] T_HI = 32'h7A879D8A;

  logic [0:0]  state_q;
  logic [31:0] win_q [16];
  logic [5:0]  round_q;
  logic        done_q;
  logic [31:0] mix;
  logic [31:0] p1;
  logic [31:0] new_w;
  logic        last_round;
  logic        handshake;

  function automatic logic [31:0] rotl(input logic [31:0] x, input logic [4:0] n);
    logic [63:0] d;
    d = {x, x} << n;
    return d[63:32];
  endfunction

  // window[k] holds W_(j+k), so the recurrence only reaches fixed taps
  always_comb begin
    mix   = win_q[0] ^ win_q[7] ^ rotl(win_q[13], 5'd15);
    p1    = mix ^ rotl(mix, 5'd15) ^ rotl(mix, 5'd23);
    new_w = p1 ^ rotl(win_q[3], 5'd7) ^ win_q[10];
  end

  assign last_round = (round_q == 6'(NUM_ROUNDS - 1));
  assign handshake  = (state_q == RUN) && w_ready_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      round_q <= 6'd0;
      done_q  <= 1'b0;
      for (int k = 0; k < 16; k++) win_q[k] <= 32'd0;
    end else if (flush_i) begin
      state_q <= IDLE;
      round_q <= 6'd0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (state_q == IDLE) begin
        if (blk_valid_i) begin
          for (int k = 0; k < 16; k++) win_q[k] <= blk_data_i[511 - 32*k -: 32];
          round_q <= 6'd0;
          state_q <= RUN;
        end
      end else if (handshake) begin
        for (int k = 0; k < 15; k++) win_q[k] <= win_q[k+1];
        win_q[15] <= new_w;
        if (last_round) begin
          round_q <= 6'd0;
          state_q <= IDLE;
          done_q  <= 1'b1;
        end else begin
          round_q <= round_q + 6'd1;
        end
      end
    end
  end

  assign blk_ready_o   = (state_q == IDLE);
  assign w_valid_o     = (state_q == RUN);
  assign wj_o          = win_q[0];
  assign wjj_o         = win_q[0] ^ win_q[4];
  assign round_sm_16_o = (round_q < 6'd16);
  assign tj_o          = rotl(round_sm_16_o ? T_LO : T_HI, round_q[4:0]);
  assign round_o       = round_q;
  assign done_o        = done_q;

endmodule

// File: tb/tb_sm3_msg_expnd.sv
// Scoreboard bench for sm3_msg_expnd: expected rounds queued at block drive, checked at each handshake.
module tb_sm3_msg_expnd;

  logic         clk_i = 1'b0;
  logic         rst_ni = 1'b0;
  logic         flush_i = 1'b0;
  logic         blk_valid_i = 1'b0;
  logic         blk_ready_o;
  logic [511:0] blk_data_i = '0;
  logic         w_valid_o;
  logic         w_ready_i = 1'b0;
  logic [31:0]  wj_o, wjj_o, tj_o;
  logic         round_sm_16_o;
  logic [5:0]   round_o;
  logic         done_o;

  sm3_msg_expnd dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
    .blk_valid_i(blk_valid_i), .blk_ready_o(blk_ready_o), .blk_data_i(blk_data_i),
    .w_valid_o(w_valid_o), .w_ready_i(w_ready_i),
    .wj_o(wj_o), .wjj_o(wjj_o), .tj_o(tj_o),
    .round_sm_16_o(round_sm_16_o), .round_o(round_o), .done_o(done_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [31:0] wj;
    logic [31:0] wjj;
    logic [31:0] tj;
    logic        sm;
    logic [5:0]  rnd;
  } exp_t;

  exp_t exp_q[$];
  int total = 0;
  int bad = 0;
  logic [31:0] obs_wj [64];
  logic [31:0] obs_wjj[64];
  logic [31:0] obs_tj [64];
  logic [31:0] ref_wj [64];
  logic [31:0] ref_wjj[64];
  logic [31:0] ref_tj [64];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", tag, got, want);
    end
  endtask

  function automatic logic [31:0] rl(input logic [31:0] x, input int n);
    int s;
    s = n % 32;
    if (s == 0) return x;
    return (x << s) | (x >> (32 - s));
  endfunction

  function automatic logic [31:0] p1f(input logic [31:0] x);
    return x ^ rl(x, 15) ^ rl(x, 23);
  endfunction

  task automatic push_block(input logic [511:0] b);
    logic [31:0] w[68];
    exp_t e;
    for (int j = 0; j < 16; j++) w[j] = b[511 - 32*j -: 32];
    for (int j = 16; j < 68; j++)
      w[j] = p1f(w[j-16] ^ w[j-9] ^ rl(w[j-3], 15)) ^ rl(w[j-13], 7) ^ w[j-6];
    for (int j = 0; j < 64; j++) begin
      e.wj  = w[j];
      e.wjj = w[j] ^ w[j+4];
      e.tj  = rl((j < 16) ? 32'h79CC4519 : 32'h7A879D8A, j);
      e.sm  = (j < 16);
      e.rnd = 6'(j);
      exp_q.push_back(e);
    end
  endtask

  // entered and left at a negedge; returns at the first RUN cycle
  task automatic send_block(input logic [511:0] b);
    int n;
    n = 0;
    blk_data_i  = b;
    blk_valid_i = 1'b1;
    push_block(b);
    while (!blk_ready_o && n < 200) begin
      @(negedge clk_i);
      n++;
    end
    if (!blk_ready_o) check_val("accept_timeout", 32'(blk_ready_o), 32'd1);
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  task automatic drain(input int stall_pct, input int flush_at, input int pulse_at, input bit hold_valid);
    int hs, cyc;
    bit stalled, rdy, do_flush;
    logic [31:0] s_wj, s_wjj, s_tj;
    logic [5:0]  s_rnd;
    exp_t e;
    hs = 0; cyc = 0; stalled = 0;
    s_wj = '0; s_wjj = '0; s_tj = '0; s_rnd = '0;
    forever begin
      if (cyc > 1000 || exp_q.size() == 0) begin
        check_val("drain_timeout", 32'(cyc), 32'd0);
        break;
      end
      check_val("run_valid", 32'(w_valid_o), 32'd1);
      check_val("run_ready", 32'(blk_ready_o), 32'd0);
      check_val("run_done", 32'(done_o), 32'd0);
      if (stalled) begin
        check_val("stall_wj", wj_o, s_wj);
        check_val("stall_wjj", wjj_o, s_wjj);
        check_val("stall_tj", tj_o, s_tj);
        check_val("stall_rnd", 32'(round_o), 32'(s_rnd));
      end
      e = exp_q[0];
      blk_valid_i = hold_valid;
      if (int'(e.rnd) == pulse_at && !stalled) begin
        blk_valid_i = 1'b1;
        blk_data_i  = {16{$urandom()}};
      end
      do_flush = (int'(e.rnd) == flush_at);
      rdy = do_flush ? (flush_at == 63) : ($urandom_range(0, 99) >= stall_pct);
      w_ready_i = rdy;
      flush_i   = do_flush;
      if (rdy) begin
        void'(exp_q.pop_front());
        check_val("wj", wj_o, e.wj);
        check_val("wjj", wjj_o, e.wjj);
        check_val("tj", tj_o, e.tj);
        check_val("sm16", 32'(round_sm_16_o), 32'(e.sm));
        check_val("round", 32'(round_o), 32'(e.rnd));
        obs_wj[e.rnd] = wj_o; obs_wjj[e.rnd] = wjj_o; obs_tj[e.rnd] = tj_o;
        hs++;
      end else begin
        s_wj = wj_o; s_wjj = wjj_o; s_tj = tj_o; s_rnd = round_o;
      end
      stalled = !rdy;
      @(posedge clk_i);
      @(negedge clk_i);
      cyc++;
      if (do_flush) begin
        flush_i = 1'b0;
        w_ready_i = 1'b0;
        for (int i = hs; i < 64; i++) void'(exp_q.pop_front());
        check_val("flush_ready", 32'(blk_ready_o), 32'd1);
        check_val("flush_valid", 32'(w_valid_o), 32'd0);
        check_val("flush_done", 32'(done_o), 32'd0);
        check_val("flush_round", 32'(round_o), 32'd0);
        @(posedge clk_i);
        @(negedge clk_i);
        check_val("flush_done_late", 32'(done_o), 32'd0);
        break;
      end
      if (hs == 64) begin
        w_ready_i = 1'b0;
        check_val("done_pulse", 32'(done_o), 32'd1);
        check_val("done_ready", 32'(blk_ready_o), 32'd1);
        check_val("done_valid", 32'(w_valid_o), 32'd0);
        check_val("done_round", 32'(round_o), 32'd0);
        break;
      end
    end
  endtask

  function automatic logic [511:0] rand_blk();
    logic [511:0] b;
    for (int i = 0; i < 16; i++) b[32*i +: 32] = $urandom();
    return b;
  endfunction

  logic [511:0] abc;
  logic [511:0] blk_b;

  initial begin
    abc = {32'h61626380, {14{32'h00000000}}, 32'h00000018};
    repeat (3) @(negedge clk_i);
    check_val("rst_ready", 32'(blk_ready_o), 32'd1);
    check_val("rst_valid", 32'(w_valid_o), 32'd0);
    check_val("rst_wj", wj_o, 32'd0);
    check_val("rst_tj", tj_o, 32'h79CC4519);
    check_val("rst_sm16", 32'(round_sm_16_o), 32'd1);
    rst_ni = 1'b1;
    @(negedge clk_i);

    // unstalled "abc" with known reference words
    send_block(abc);
    drain(0, -1, -1, 1'b0);
    check_val("abc_j0_wj", obs_wj[0], 32'h61626380);
    check_val("abc_j0_wjj", obs_wjj[0], 32'h61626380);
    check_val("abc_j0_tj", obs_tj[0], 32'h79CC4519);
    check_val("abc_j1_tj", obs_tj[1], 32'hF3988A32);
    check_val("abc_j12_wjj", obs_wjj[12], 32'h9092E200);
    check_val("abc_j16_wj", obs_wj[16], 32'h9092E200);
    check_val("abc_j16_tj", obs_tj[16], 32'h9D8A7A87);
    check_val("abc_j19_wj", obs_wj[19], 32'h719C70ED);
    check_val("abc_j31_wj", obs_wj[31], 32'hB2D12F1B);
    for (int j = 0; j < 64; j++) begin
      ref_wj[j] = obs_wj[j]; ref_wjj[j] = obs_wjj[j]; ref_tj[j] = obs_tj[j];
    end

    // same block, random stalls: identical sequence
    send_block(abc);
    drain(40, -1, -1, 1'b0);
    for (int j = 0; j < 64; j++) begin
      check_val("stall_seq_wj", obs_wj[j], ref_wj[j]);
      check_val("stall_seq_wjj", obs_wjj[j], ref_wjj[j]);
      check_val("stall_seq_tj", obs_tj[j], ref_tj[j]);
    end

    // back-to-back with valid held high
    send_block(rand_blk());
    blk_b = rand_blk();
    blk_data_i = blk_b;
    push_block(blk_b);
    drain(0, -1, -1, 1'b1);
    @(posedge clk_i);
    @(negedge clk_i);
    check_val("b2b_valid", 32'(w_valid_o), 32'd1);
    check_val("b2b_round", 32'(round_o), 32'd0);
    drain(20, -1, -1, 1'b0);

    // flushes, then a clean block
    send_block(rand_blk());
    drain(0, 37, -1, 1'b0);
    send_block(rand_blk());
    drain(0, 63, -1, 1'b0);
    send_block(abc);
    drain(0, -1, -1, 1'b0);

    // stray blk_valid_i during RUN
    send_block(rand_blk());
    drain(10, -1, 20, 1'b0);

    // asynchronous reset mid-RUN
    send_block(abc);
    blk_valid_i = 1'b0;
    w_ready_i = 1'b1;
    repeat (10) begin
      void'(exp_q.pop_front());
      @(posedge clk_i);
      @(negedge clk_i);
    end
    w_ready_i = 1'b0;
    #2;
    rst_ni = 1'b0;
    #1;
    check_val("arst_valid", 32'(w_valid_o), 32'd0);
    check_val("arst_ready", 32'(blk_ready_o), 32'd1);
    check_val("arst_wj", wj_o, 32'd0);
    check_val("arst_wjj", wjj_o, 32'd0);
    check_val("arst_round", 32'(round_o), 32'd0);
    check_val("arst_sm16", 32'(round_sm_16_o), 32'd1);
    check_val("arst_tj", tj_o, 32'h79CC4519);
    check_val("arst_done", 32'(done_o), 32'd0);
    exp_q.delete();
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);
    check_val("post_rst_ready", 32'(blk_ready_o), 32'd1);
    check_val("post_rst_tj", tj_o, 32'h79CC4519);
    check_val("post_rst_done", 32'(done_o), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
